// File: rtl/am_pkg.sv
// Shared constants for 40GBASE-R alignment marker insertion: per-lane marker
// bytes, control sync header and the BIP3 bit-interleaved parity function.
package am_pkg;

    localparam int AM_LANES   = 4;
    localparam int AM_BLOCK_W = 66;

    typedef logic [7:0]            byte_t;
    typedef logic [AM_BLOCK_W-1:0] block_t;

    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam byte_t AM_M0 [AM_LANES] = '{8'h90, 8'hF0, 8'hC5, 8'hA2};
    localparam byte_t AM_M1 [AM_LANES] = '{8'h76, 8'hC4, 8'h65, 8'h79};
    localparam byte_t AM_M2 [AM_LANES] = '{8'h47, 8'hE6, 8'h9B, 8'h3D};

    // Payload bit j lands on BIP bit (j-2) mod 8, so the parity is the XOR of
    // the eight payload bytes; the two sync bits fold into BIP bits 3 and 4.
    function automatic byte_t bip8_f(input block_t blk);
        byte_t p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p = p ^ blk[2 + 8*k +: 8];
        end
        p[3] = p[3] ^ blk[0];
        p[4] = p[4] ^ blk[1];
        return p;
    endfunction

endpackage

// File: rtl/am_bip_lane.sv
// One PCS lane: running BIP3 accumulator and the registered output mux that
// selects between this lane's alignment marker and the incoming data block.
module am_bip_lane
    import am_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic   clk,
    input  logic   nreset,
    input  logic   i_am,
    input  logic   i_data_en,
    input  block_t i_data,
    output block_t o_data
);

    byte_t  r_acc;
    block_t r_data;
    block_t w_am;

    // The marker carries the parity accumulated since the previous marker.
    assign w_am = {~r_acc, ~AM_M2[LANE], ~AM_M1[LANE], ~AM_M0[LANE],
                   r_acc,  AM_M2[LANE],  AM_M1[LANE],  AM_M0[LANE], SYNC_CTRL};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_acc  <= '0;
            r_data <= '0;
        end else if (i_am) begin
            r_data <= w_am;
            r_acc  <= bip8_f(w_am);
        end else if (i_data_en) begin
            r_data <= i_data;
            r_acc  <= r_acc ^ bip8_f(i_data);
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/am_insert_tx.sv
// TX alignment marker insertion: after every AM_GAP accepted blocks, stall
// upstream for one cycle and emit a marker on every lane simultaneously.
module am_insert_tx
    import am_pkg::*;
#(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = AM_BLOCK_W,
    parameter int AM_GAP  = 16383
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      valid_i,
    input  logic [LANE_N*BLOCK_W-1:0] data_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic                      am_o,
    output logic [LANE_N*BLOCK_W-1:0] data_o
);

    localparam int CNT_W = $clog2(AM_GAP + 1);

    logic             r_am_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_am;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign ready_o   = ~r_am_pend;
    assign w_accept  = valid_i & ~r_am_pend;
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    // NOTE: all state updates use non-blocking assignments so every flop samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_am_pend <= 1'b1;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_am      <= 1'b0;
        end else if (r_am_pend) begin
            r_am_pend <= 1'b0;
            r_cnt     <= '0;
            r_valid   <= 1'b1;
            r_am      <= 1'b1;
        end else begin
            r_valid <= valid_i;
            r_am    <= 1'b0;
            if (valid_i) begin
                r_cnt <= w_cnt_nxt;
                if (w_cnt_nxt == CNT_W'(AM_GAP)) begin
                    r_am_pend <= 1'b1;
                end
            end
        end
    end

    assign valid_o = r_valid;
    assign am_o    = r_am;

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        am_bip_lane #(
            .LANE (l)
        ) u_lane (
            .clk       (clk),
            .nreset    (nreset),
            .i_am      (r_am_pend),
            .i_data_en (w_accept),
            .i_data    (data_i[l*BLOCK_W +: BLOCK_W]),
            .o_data    (data_o[l*BLOCK_W +: BLOCK_W])
        );
    end

endmodule

// File: tb/tb_am_insert_tx.sv
// Directed bench for am_insert_tx with AM_GAP=4: a behavioural model queues the
// expected output of each cycle and immediate assertions compare after the edge.
module tb_am_insert_tx;

    localparam int LANES = 4;
    localparam int BW    = 66;
    localparam int GAP   = 4;
    localparam int DW    = LANES * BW;

    typedef struct {
        logic          valid;
        logic          am;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          nreset;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic          am_o;
    logic [DW-1:0] data_o;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q[$];

    logic          m_pend;
    int            m_cnt;
    logic [7:0]    m_acc  [LANES];
    logic [BW-1:0] m_data [LANES];
    int            m_ams;
    int            seen_ams;

    logic [7:0] t_m0 [LANES] = '{8'h90, 8'hF0, 8'hC5, 8'hA2};
    logic [7:0] t_m1 [LANES] = '{8'h76, 8'hC4, 8'h65, 8'h79};
    logic [7:0] t_m2 [LANES] = '{8'h47, 8'hE6, 8'h9B, 8'h3D};

    am_insert_tx #(
        .LANE_N  (LANES),
        .BLOCK_W (BW),
        .AM_GAP  (GAP)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .am_o    (am_o),
        .data_o  (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference parity, walked bit by bit from the block bit map.
    function automatic logic [7:0] ref_bip(input logic [BW-1:0] blk);
        logic [7:0] p;
        logic [2:0] bi;
        p = '0;
        for (int j = 2; j < BW; j++) begin
            bi = 3'((j - 2) % 8);
            p[bi] = p[bi] ^ blk[j];
        end
        if (blk[0]) p[3] = ~p[3];
        if (blk[1]) p[4] = ~p[4];
        return p;
    endfunction

    function automatic logic [BW-1:0] ref_am(input int l, input logic [7:0] bip);
        logic [BW-1:0] a;
        a        = '0;
        a[1:0]   = 2'b01;
        a[9:2]   = t_m0[l];
        a[17:10] = t_m1[l];
        a[25:18] = t_m2[l];
        a[33:26] = bip;
        a[41:34] = ~t_m0[l];
        a[49:42] = ~t_m1[l];
        a[57:50] = ~t_m2[l];
        a[65:58] = ~bip;
        return a;
    endfunction

    task automatic model_reset();
        m_pend = 1'b1;
        m_cnt  = 0;
        for (int l = 0; l < LANES; l++) begin
            m_acc[l]  = '0;
            m_data[l] = '0;
        end
    endtask

    // One clock cycle: drive, predict, push; after the edge pop and compare.
    task automatic step(input logic v, input logic [DW-1:0] d);
        exp_t e;
        exp_t got;
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        #1;
        check("ready_o", DW'(ready_o), DW'(!m_pend));
        if (m_pend) begin
            e.valid = 1'b1;
            e.am    = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                m_data[l] = ref_am(l, m_acc[l]);
                m_acc[l]  = ref_bip(m_data[l]);
            end
            m_pend = 1'b0;
            m_cnt  = 0;
            m_ams++;
        end else begin
            e.valid = v;
            e.am    = 1'b0;
            if (v) begin
                for (int l = 0; l < LANES; l++) begin
                    m_data[l] = d[l*BW +: BW];
                    m_acc[l]  = m_acc[l] ^ ref_bip(m_data[l]);
                end
                m_cnt++;
                if (m_cnt == GAP) m_pend = 1'b1;
            end
        end
        for (int l = 0; l < LANES; l++) e.data[l*BW +: BW] = m_data[l];
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        if (am_o === 1'b1) seen_ams++;
        check("valid_o", DW'(valid_o), DW'(got.valid));
        check("am_o",    DW'(am_o),    DW'(got.am));
        check("data_o",  data_o,       got.data);
    endtask

    function automatic logic [DW-1:0] zero_blocks();
        logic [DW-1:0] z;
        z = '0;
        for (int l = 0; l < LANES; l++) z[l*BW +: 2] = 2'b10;
        return z;
    endfunction

    function automatic logic [DW-1:0] rand_blocks();
        logic [DW-1:0] r;
        for (int w = 0; w < DW; w += 32) r[w +: 32] = 32'($urandom);
        for (int l = 0; l < LANES; l++) r[l*BW +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        return r;
    endfunction

    logic [BW-1:0] am1_lane0;

    initial begin
        am1_lane0 = {8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b01};
        m_ams    = 0;
        seen_ams = 0;
        nreset   = 1'b0;
        valid_i  = 1'b0;
        data_i   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst valid_o", DW'(valid_o), '0);
        check("rst am_o",    DW'(am_o),    '0);
        check("rst data_o",  data_o,       '0);
        check("rst ready_o", DW'(ready_o), '0);
        #1 nreset = 1'b1;

        // First AM, then zero blocks with sync 10 up to the second AM.
        step(1'b1, zero_blocks());
        check("am1 lane0", DW'(data_o[BW-1:0]), DW'(am1_lane0));
        repeat (GAP) step(1'b1, zero_blocks());
        step(1'b1, zero_blocks());
        check("am2 lane0 bip3", DW'(data_o[33:26]), DW'(8'h08));
        check("am2 lane0 bip7", DW'(data_o[65:58]), DW'(8'hF7));

        // Continuous random traffic: AM count over the window must match.
        m_ams    = 0;
        seen_ams = 0;
        repeat (15) step(1'b1, rand_blocks());
        check("am count", DW'(seen_ams), DW'(m_ams));

        // Bring to a fresh AM, then idle 3 cycles mid-gap.
        while (!m_pend) step(1'b1, rand_blocks());
        step(1'b1, rand_blocks());
        repeat (2) step(1'b1, rand_blocks());
        repeat (3) step(1'b0, rand_blocks());
        repeat (2) step(1'b1, rand_blocks());
        check("pend after 4", DW'(ready_o), '0);

        // valid_i low during the AM slot.
        step(1'b0, rand_blocks());
        check("am idle slot", DW'({valid_o, am_o}), DW'(2'b11));

        // Asynchronous reset with the counter at 2.
        repeat (2) step(1'b1, rand_blocks());
        @(posedge clk);
        #3 nreset = 1'b0;
        #1;
        check("arst valid_o", DW'(valid_o), '0);
        check("arst am_o",    DW'(am_o),    '0);
        check("arst data_o",  data_o,       '0);
        model_reset();
        @(posedge clk);
        #2 nreset = 1'b1;
        step(1'b1, rand_blocks());
        check("post-rst bip3", DW'(data_o[33:26]), '0);

        // Random valid pattern.
        for (int i = 0; i < 30; i++) begin
            step(($urandom_range(0, 3) != 0), rand_blocks());
        end
        check("queue empty", DW'(q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
